// File: rtl/matmul_tile_sequencer.sv
// Splits one large matmul job into DIM x DIM output tiles, issues them one at a time
// to the systolic core and returns a single completion response after the last tile.
module matmul_tile_sequencer #(
  parameter int unsigned SYSTOLIC_ARRAY_DIM = 8,
  parameter int unsigned DATA_WIDTH_BITS    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [63:0] cmd_act_addr_i,
  input  logic [63:0] cmd_wgt_addr_i,
  input  logic [63:0] cmd_out_addr_i,
  input  logic [15:0] cmd_m_tiles_i,
  input  logic [15:0] cmd_n_tiles_i,
  input  logic [19:0] cmd_inner_dimension_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_tile_count_o,
  output logic        tile_cmd_valid_o,
  input  logic        tile_cmd_ready_i,
  output logic [63:0] tile_cmd_act_addr_o,
  output logic [63:0] tile_cmd_wgt_addr_o,
  output logic [63:0] tile_cmd_out_addr_o,
  output logic [19:0] tile_cmd_inner_dimension_o,
  input  logic        tile_resp_valid_i,
  output logic        tile_resp_ready_o
);

  localparam int unsigned Bytes      = DATA_WIDTH_BITS / 8;
  localparam logic [63:0] TileBytes  = 64'(Bytes * SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM);
  localparam logic [63:0] PanelScale = 64'(Bytes * SYSTOLIC_ARRAY_DIM);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] act_cur_q, act_cur_d;
  logic [63:0] wgt_cur_q, wgt_cur_d;
  logic [63:0] out_cur_q, out_cur_d;
  logic [63:0] wgt_base_q, wgt_base_d;
  logic [63:0] panel_q, panel_d;
  logic [19:0] k_q, k_d;
  logic [15:0] m_tiles_q, m_tiles_d;
  logic [15:0] n_tiles_q, n_tiles_d;
  logic [15:0] mt_q, mt_d;
  logic [15:0] nt_q, nt_d;
  logic [31:0] count_q, count_d;

  logic last_col, last_row, empty_job;

  assign last_col  = (nt_q == n_tiles_q - 16'd1);
  assign last_row  = (mt_q == m_tiles_q - 16'd1);
  assign empty_job = (cmd_m_tiles_i == '0) || (cmd_n_tiles_i == '0) ||
                     (cmd_inner_dimension_i == '0);

  always_comb begin
    state_d    = state_q;
    act_cur_d  = act_cur_q;
    wgt_cur_d  = wgt_cur_q;
    out_cur_d  = out_cur_q;
    wgt_base_d = wgt_base_q;
    panel_d    = panel_q;
    k_d        = k_q;
    m_tiles_d  = m_tiles_q;
    n_tiles_d  = n_tiles_q;
    mt_d       = mt_q;
    nt_d       = nt_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          act_cur_d  = cmd_act_addr_i;
          wgt_cur_d  = cmd_wgt_addr_i;
          out_cur_d  = cmd_out_addr_i;
          wgt_base_d = cmd_wgt_addr_i;
          k_d        = cmd_inner_dimension_i;
          m_tiles_d  = cmd_m_tiles_i;
          n_tiles_d  = cmd_n_tiles_i;
          // The only multiply of the job; per-tile stepping is add-only.
          panel_d    = PanelScale * {44'd0, cmd_inner_dimension_i};
          mt_d       = '0;
          nt_d       = '0;
          count_d    = '0;
          state_d    = empty_job ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (tile_cmd_ready_i) begin
          count_d = count_q + 32'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (tile_resp_valid_i) begin
          if (!last_col) begin
            nt_d      = nt_q + 16'd1;
            wgt_cur_d = wgt_cur_q + panel_q;
          end else begin
            nt_d      = '0;
            wgt_cur_d = wgt_base_q;
            mt_d      = mt_q + 16'd1;
            act_cur_d = act_cur_q + panel_q;
          end
          out_cur_d = out_cur_q + TileBytes;
          state_d   = (last_col && last_row) ? StDone : StIssue;
        end
      end
      StDone: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      act_cur_q  <= '0;
      wgt_cur_q  <= '0;
      out_cur_q  <= '0;
      wgt_base_q <= '0;
      panel_q    <= '0;
      k_q        <= '0;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      act_cur_q  <= act_cur_d;
      wgt_cur_q  <= wgt_cur_d;
      out_cur_q  <= out_cur_d;
      wgt_base_q <= wgt_base_d;
      panel_q    <= panel_d;
      k_q        <= k_d;
      m_tiles_q  <= m_tiles_d;
      n_tiles_q  <= n_tiles_d;
      mt_q       <= mt_d;
      nt_q       <= nt_d;
      count_q    <= count_d;
    end
  end

  assign cmd_ready_o                = (state_q == StIdle);
  assign tile_cmd_valid_o           = (state_q == StIssue);
  assign tile_resp_ready_o          = (state_q == StWait);
  assign resp_valid_o               = (state_q == StDone);
  assign resp_tile_count_o          = count_q;
  assign tile_cmd_act_addr_o        = act_cur_q;
  assign tile_cmd_wgt_addr_o        = wgt_cur_q;
  assign tile_cmd_out_addr_o        = out_cur_q;
  assign tile_cmd_inner_dimension_o = k_q;

endmodule
